// File: rtl/layer_stream_ctrl.sv
// Collects NN parallel neuron outputs into a frame, then replays them
// as a serial stream (neuron 0 first) for the next fully-connected layer.
module layer_stream_ctrl #(
    parameter int NN        = 30,
    parameter int dataWidth = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NN-1:0]           in_valid,
    input  logic [NN*dataWidth-1:0] in_data,
    input  logic                    err_clr,
    output logic                    x_valid,
    output logic [dataWidth-1:0]    x_in,
    output logic                    x_last,
    output logic                    busy,
    output logic                    overrun,
    output logic [7:0]              frame_cnt
);

    localparam int IW = (NN > 1) ? $clog2(NN) : 1;
    localparam logic [IW-1:0] LAST = IW'(NN - 1);

    typedef enum logic {COLLECT, SHIFT} state_t;

    state_t               state;
    logic [NN-1:0]        mask;
    logic [IW-1:0]        idx;
    logic [dataWidth-1:0] cap_buf [NN];
    logic [NN-1:0]        mask_n;
    logic                 ovr_set;

    always_comb begin
        mask_n  = mask | in_valid;
        ovr_set = 1'b0;
        if (state == SHIFT) ovr_set = |in_valid;
        else                ovr_set = |(in_valid & mask);
    end

    assign busy = (state == SHIFT) | (|mask);

    // First report of a neuron wins; repeats only raise overrun.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NN; i++) begin
            if (state == COLLECT && in_valid[i] && !mask[i])
                cap_buf[i] <= in_data[i*dataWidth +: dataWidth];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= COLLECT;
            mask      <= '0;
            idx       <= '0;
            x_valid   <= 1'b0;
            x_in      <= '0;
            x_last    <= 1'b0;
            overrun   <= 1'b0;
            frame_cnt <= '0;
        end else begin
            x_valid <= 1'b0;
            x_last  <= 1'b0;
            if (err_clr) overrun <= 1'b0;
            if (ovr_set) overrun <= 1'b1;
            case (state)
                COLLECT: begin
                    if (&mask_n) begin
                        state <= SHIFT;
                        mask  <= '0;
                        idx   <= '0;
                    end else begin
                        mask <= mask_n;
                    end
                end
                SHIFT: begin
                    x_valid <= 1'b1;
                    x_in    <= cap_buf[idx];
                    x_last  <= (idx == LAST);
                    if (idx == LAST) begin
                        state     <= COLLECT;
                        idx       <= '0;
                        frame_cnt <= frame_cnt + 8'd1;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Directed bench for layer_stream_ctrl with NN=30, dataWidth=16.
module tb_layer_stream_ctrl;

    localparam int NN = 30;
    localparam int DW = 16;

    logic              clk;
    logic              rst;
    logic [NN-1:0]     in_valid;
    logic [NN*DW-1:0]  in_data;
    logic              err_clr;
    logic              x_valid;
    logic [DW-1:0]     x_in;
    logic              x_last;
    logic              busy;
    logic              overrun;
    logic [7:0]        frame_cnt;

    int vectors = 0;
    int miscompares = 0;
    logic [DW-1:0] exp_v [NN];
    logic [7:0] exp_fc;
    int ovr_seen;

    layer_stream_ctrl #(.NN(NN), .dataWidth(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .err_clr(err_clr), .x_valid(x_valid), .x_in(x_in), .x_last(x_last),
        .busy(busy), .overrun(overrun), .frame_cnt(frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [DW-1:0] base);
        for (int i = 0; i < NN; i++) begin
            in_data[i*DW +: DW] = base + DW'(i);
            exp_v[i] = base + DW'(i);
        end
    endtask

    // Call one cycle after the completing edge; checks all NN beats.
    task automatic check_replay(input string tag);
        for (int k = 0; k < NN; k++) begin
            tick();
            chk({tag, "_xv"}, 32'(x_valid), 32'd1);
            chk({tag, "_xin"}, 32'(x_in), 32'(exp_v[k]));
            chk({tag, "_xlast"}, 32'(x_last), 32'(k == NN - 1));
        end
    endtask

    initial begin
        rst = 1'b0;
        in_valid = '0;
        in_data = '0;
        err_clr = 1'b0;
        #12;
        chk("rst_xv", 32'(x_valid), 32'd0);
        chk("rst_xin", 32'(x_in), 32'd0);
        chk("rst_xlast", 32'(x_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_fc", 32'(frame_cnt), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // all at once, value i+1
        load(16'd1);
        in_valid = '1;
        tick();
        in_valid = '0;
        chk("aao_busy", 32'(busy), 32'd1);
        chk("aao_xv0", 32'(x_valid), 32'd0);
        check_replay("aao");
        tick();
        chk("aao_xv_end", 32'(x_valid), 32'd0);
        chk("aao_fc", 32'(frame_cnt), 32'd1);
        chk("aao_ovr", 32'(overrun), 32'd0);
        chk("aao_busy_end", 32'(busy), 32'd0);

        // staggered 29..0
        load(16'h0100);
        for (int i = NN - 1; i >= 0; i--) begin
            in_valid = '0;
            in_valid[i] = 1'b1;
            tick();
            if (i == NN - 1) chk("stg_busy", 32'(busy), 32'd1);
            if (i == 1) chk("stg_xv_pre", 32'(x_valid), 32'd0);
        end
        in_valid = '0;
        chk("stg_xv0", 32'(x_valid), 32'd0);
        check_replay("stg");
        tick();
        chk("stg_fc", 32'(frame_cnt), 32'd2);

        // duplicate report on neuron 5
        load(16'h0200);
        in_data[5*DW +: DW] = 16'h0011;
        in_valid = '0;
        in_valid[5] = 1'b1;
        tick();
        chk("dup_ovr0", 32'(overrun), 32'd0);
        in_data[5*DW +: DW] = 16'h0022;
        tick();
        chk("dup_ovr1", 32'(overrun), 32'd1);
        in_valid = '1;
        in_valid[5] = 1'b0;
        tick();
        in_valid = '0;
        exp_v[5] = 16'h0011;
        check_replay("dup");
        tick();
        chk("dup_fc", 32'(frame_cnt), 32'd3);
        chk("dup_ovr_hold", 32'(overrun), 32'd1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("dup_clr", 32'(overrun), 32'd0);

        // strobe during replay
        load(16'h0300);
        in_valid = '1;
        tick();
        in_valid = '0;
        for (int k = 0; k < NN; k++) begin
            tick();
            in_valid = '0;
            chk("sdr_xin", 32'(x_in), 32'(exp_v[k]));
            chk("sdr_xlast", 32'(x_last), 32'(k == NN - 1));
            if (k == 2) begin
                in_data[3*DW +: DW] = 16'hBEEF;
                in_valid[3] = 1'b1;
            end
        end
        chk("sdr_ovr", 32'(overrun), 32'd1);
        tick();
        chk("sdr_busy", 32'(busy), 32'd0);
        chk("sdr_fc", 32'(frame_cnt), 32'd4);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("sdr_clr", 32'(overrun), 32'd0);
        load(16'h0400);
        in_valid = '1;
        tick();
        in_valid = '0;
        check_replay("sdr_next");
        tick();
        chk("sdr_next_fc", 32'(frame_cnt), 32'd5);

        // reset at beat 10
        load(16'h0500);
        in_valid = '1;
        tick();
        in_valid = '0;
        for (int k = 0; k <= 10; k++) tick();
        chk("rmr_xv_pre", 32'(x_valid), 32'd1);
        chk("rmr_xin_pre", 32'(x_in), 32'h050A);
        #2;
        rst = 1'b0;
        #1;
        chk("rmr_xv", 32'(x_valid), 32'd0);
        chk("rmr_xlast", 32'(x_last), 32'd0);
        chk("rmr_fc", 32'(frame_cnt), 32'd0);
        chk("rmr_busy", 32'(busy), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        chk("rmr_xv_after", 32'(x_valid), 32'd0);
        load(16'h0600);
        in_valid = '1;
        tick();
        in_valid = '0;
        check_replay("rmr_fresh");
        tick();
        chk("rmr_fresh_fc", 32'(frame_cnt), 32'd1);

        // 256 back-to-back frames at period NN+1
        exp_fc = 8'd1;
        ovr_seen = 0;
        for (int f = 0; f < 256; f++) begin
            load(DW'(f * 64));
            in_valid = '1;
            tick();
            in_valid = '0;
            for (int k = 0; k < NN; k++) begin
                tick();
                if (overrun) ovr_seen++;
            end
            exp_fc = exp_fc + 8'd1;
            chk("b2b_fc", 32'(frame_cnt), 32'(exp_fc));
            chk("b2b_last", 32'(x_in), 32'(exp_v[NN-1]));
        end
        chk("b2b_ovr", 32'(ovr_seen), 32'd0);
        chk("b2b_wrap", 32'(frame_cnt), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/layer_stream_ctrl.md
# layer_stream_ctrl

Sequencer between two fully-connected layers. It collects the NN parallel neuron outputs of one layer, whose `o_valid` bits may arrive in any order and over several cycles. Once every neuron has reported, it replays the captured values as a serial `x_valid`/`x_in` stream for the next layer, one value per clock, neuron 0 first. It also flags protocol violations: a neuron reporting twice in one frame, or any neuron reporting while replay is in progress.

## Interface
Parameters:
- `NN`, 30: neurons in the upstream layer; valid range 1..255.
- `dataWidth`, 16: width of one neuron output.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `in_valid`, in, NN: per-neuron output strobe; bit i comes from neuron i of the upstream layer.
- `in_data`, in, NN*dataWidth: neuron i's value occupies bits `[i*dataWidth +: dataWidth]`.
- `x_valid`, out, 1: serial beat valid, to the next layer.
- `x_in`, out, dataWidth: serial beat data.
- `x_last`, out, 1: high on the final beat (neuron NN-1) of each frame.
- `busy`, out, 1: high while collecting a partial frame or replaying.
- `overrun`, out, 1: sticky protocol-error flag.
- `err_clr`, in, 1: synchronous clear of `overrun`.
- `frame_cnt`, out, 8: count of completed replays; wraps modulo 256.

## Operation
- Registers:
  - `buf[NN]`, dataWidth each: capture buffer.
  - `mask`, NN bits: which neurons have reported this frame.
  - `idx`, max(1, clog2(NN)) bits: replay pointer.
  - `state`: one of COLLECT, SHIFT.
- Reset (rst low, asynchronous):
  - state=COLLECT, mask=0, idx=0.
  - x_valid=0, x_in=0, x_last=0, overrun=0, frame_cnt=0.
  - buf contents are don't-care.
- COLLECT, per edge, for each bit i:
  - If in_valid[i]=1 and mask[i]=0: buf[i] takes the value of neuron i's slice of in_data, and mask[i] is set.
  - If in_valid[i]=1 and mask[i]=1: overrun is set. buf[i] is not overwritten; the first value wins.
- COLLECT → SHIFT: taken at the edge where (mask | accepted in_valid) becomes all-ones. At that same edge mask clears and idx is set to 0.
- SHIFT, per edge:
  - x_valid=1 and x_in=buf[idx].
  - x_last=1 when idx=NN-1.
  - idx increments.
- SHIFT → COLLECT: at the edge that emits idx=NN-1. At that edge idx returns to 0 and frame_cnt increments.
- Any in_valid bit high while in SHIFT sets overrun. The data is discarded and mask is unchanged.
- x_valid and x_last are 0 on every edge that does not emit a beat. x_in holds its last value.
- busy = (state==SHIFT) | (mask!=0). It is combinational from registers.
- `err_clr`:
  - Clears overrun at the edge.
  - If a new overrun condition occurs at the same edge, set wins.
- NN=1: a single in_valid pulse moves to SHIFT. One beat then follows, with x_last=1.

## Timing
- Let E be the edge that completes the mask.
  - Beat k (k=0..NN-1) is registered at edge E+1+k.
  - x_valid is high for exactly NN consecutive cycles.
  - The first beat is visible one cycle after completion.
- Latency from last in_valid to first x_valid: 1 clock. Replay takes NN clocks.
- In_valid is accepted again from the edge after the one that emits x_last. Frames can therefore run back-to-back at a period of NN+1 clocks.
- No backpressure. Downstream must accept one beat per clock while x_valid=1.
- If rst is asserted mid-replay, output stops immediately: x_valid and x_last are 0 asynchronously. The partial frame is lost. After release, state is COLLECT with an empty mask.

## Test plan
- All-at-once frame:
  - Stimulus: NN=30, all in_valid bits pulse for one cycle, with neuron i value = i+1.
  - Required: one cycle later x_valid runs for 30 cycles with x_in = 1, 2, …, 30; x_last only on value 30; frame_cnt=1; overrun=0.
- Staggered frame:
  - Stimulus: neurons 29..0 report one per cycle in descending order.
  - Required: busy goes high after the first strobe; x_valid starts one cycle after neuron 0's strobe; output order is still 0..29.
- Duplicate report:
  - Stimulus: neuron 5 reports 0x0011, then reports 0x0022 before the frame completes.
  - Required: overrun=1; beat 5 carries 0x0011.
  - Then: pulse err_clr. Required: overrun=0 at the next edge.
- Strobe during replay:
  - Stimulus: during replay, in_valid[3] pulses with 0xBEEF.
  - Required: overrun=1; the current replay is unaffected; the next frame's mask starts empty and later collects normally.
- Reset mid-replay:
  - Stimulus: drive rst low at beat 10.
  - Required: x_valid drops without waiting for a clock edge; frame_cnt=0; busy=0. A fresh full frame afterwards replays all 30 beats correctly.
- Back-to-back frames and wrap:
  - Stimulus: 256 back-to-back frames at period NN+1.
  - Required: no overrun; frame_cnt wraps 255→0.
